parser_ingress_arbiter: RTL

- Frame-granular round-robin arbiter that shares one parser pipeline (Ethernet → IPv4 → L4 parsers) between N ingress byte-lane streams.
- Locks the grant to one source from its first accepted beat until its last-flagged beat, and tags each forwarded beat with its source.
- Enforces a maximum frame length. Over-length frames are truncated and their remainder is drained.
- Sits between the MAC/DMA ingress adapters and the first parser stage.

---
 rtl/parser_pkg.sv | 20 ++
 rtl/parser_ingress_arbiter_rr_pick.sv | 33 +++
 rtl/parser_ingress_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/parser_pkg.sv
// Shared types and width helpers for the parser ingress path.
package parser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Width of a valid-byte count able to express 0..DATA_WIDTH/8.
  function automatic int idx_w(input int data_width);
    return $clog2(data_width / 8 + 1);
  endfunction

  // Width of a port index; never narrower than one bit.
  function automatic int port_w(input int n_ports);
    return (n_ports > 1) ? $clog2(n_ports) : 1;
  endfunction

endpackage

// File: rtl/parser_ingress_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after rr_last wins.
module rr_pick
  import parser_pkg::*;
#(
  parameter  int N_PORTS = 2,
  localparam int PORT_W  = port_w(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PORT_W-1:0]  rr_last,
  output logic [PORT_W-1:0]  grant,
  output logic               any_req
);

  logic [2*N_PORTS-1:0] req2;
  logic [N_PORTS-1:0]   rot;

  // Rotate so that bit 0 is the port just after the last winner.
  assign req2 = {req, req} >> (int'(rr_last) + 1);
  assign rot  = req2[N_PORTS-1:0];

  // Lowest set bit of the rotated vector, mapped back to a port index.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int j = 0; j < N_PORTS; j++) begin
      if (!any_req && rot[j]) begin
        any_req = 1'b1;
        grant   = PORT_W'((int'(rr_last) + 1 + j) % N_PORTS);
      end
    end
  end

endmodule

// File: rtl/parser_ingress_arbiter.sv
// Frame-granular round-robin arbiter feeding the parser pipeline; truncates
// over-length frames and drains their remainder.
module parser_ingress_arbiter
  import parser_pkg::*;
#(
  parameter  int DATA_WIDTH      = 64,
  parameter  int N_PORTS         = 2,
  parameter  int MAX_FRAME_BEATS = 192,
  localparam int IDX_W           = idx_w(DATA_WIDTH),
  localparam int PORT_W          = port_w(N_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [N_PORTS*IDX_W-1:0]      s_idx,
  input  logic [N_PORTS-1:0]            s_valid,
  input  logic [N_PORTS-1:0]            s_last,
  output logic [N_PORTS-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic [IDX_W-1:0]              m_idx,
  output logic                          m_valid,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic [PORT_W-1:0]             m_src,
  output logic                          trunc_pulse,
  output logic [PORT_W-1:0]             trunc_port,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MAX_FRAME_BEATS + 1);

  arb_state_t            state, state_nxt;
  logic [PORT_W-1:0]     grant, rr_last, pick;
  logic                  any_req;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  out_en, accept, at_max;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_valid, sel_last;

  rr_pick #(.N_PORTS(N_PORTS)) u_rr_pick (
    .req     (s_valid),
    .rr_last (rr_last),
    .grant   (pick),
    .any_req (any_req)
  );

  assign out_en    = !m_valid || m_ready;
  assign sel_data  = s_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
  assign sel_idx   = s_idx[grant*IDX_W +: IDX_W];
  assign sel_valid = s_valid[grant];
  assign sel_last  = s_last[grant];
  assign accept    = sel_valid && s_ready[grant];
  assign at_max    = (beat_cnt == CNT_W'(MAX_FRAME_BEATS - 1));
  assign busy      = (state != IDLE);

  // Only the granted port is ever readied; DRAIN swallows beats regardless of the parser.
  always_comb begin
    s_ready = '0;
    case (state)
      FWD:     s_ready[grant] = out_en;
      DRAIN:   s_ready[grant] = 1'b1;
      default: s_ready = '0;
    endcase
  end

  // Next-state: grant on any request, leave on last beat or forced truncation.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (any_req) state_nxt = FWD;
      FWD: begin
        if (accept) begin
          if (sel_last)    state_nxt = IDLE;
          else if (at_max) state_nxt = DRAIN;
        end
      end
      DRAIN: if (accept && sel_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: grant, fairness pointer, beat counter, truncation report.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      rr_last     <= PORT_W'(N_PORTS - 1);
      beat_cnt    <= '0;
      trunc_pulse <= 1'b0;
      trunc_port  <= '0;
    end else begin
      state       <= state_nxt;
      trunc_pulse <= 1'b0;
      if (state == IDLE && any_req) begin
        grant    <= pick;
        beat_cnt <= '0;
      end
      if (state == FWD && accept) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (!sel_last && at_max) begin
          trunc_pulse <= 1'b1;
          trunc_port  <= grant;
        end
      end
      if (state != IDLE && accept && sel_last) rr_last <= grant;
    end
  end

  // Output stage: single register toward the parser, held under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_tdata <= '0;
      m_idx   <= '0;
      m_src   <= '0;
    end else if (state == FWD && accept) begin
      m_valid <= 1'b1;
      m_last  <= sel_last || at_max;
      m_tdata <= sel_data;
      m_idx   <= sel_idx;
      m_src   <= grant;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
